// File: rtl/key_reset_gen_if.sv
// rtl/key_reset_gen_if.sv - button input and reset/level/strobe outputs of key_reset_gen
interface key_reset_gen_if;
    logic key_n;
    logic core_rst_n;
    logic key_level;
    logic press_pulse;

    modport master (
        output key_n,
        input  core_rst_n,
        input  key_level,
        input  press_pulse
    );

    modport slave (
        input  key_n,
        output core_rst_n,
        output key_level,
        output press_pulse
    );
endinterface

// File: rtl/key_reset_gen.sv
// rtl/key_reset_gen.sv - button synchroniser, debouncer and stretched core reset generator
module key_reset_gen #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int STRETCH_CYCLES  = 16,
    parameter int CNT_W           = 16
) (
    input logic            clk,
    input logic            rst,
    key_reset_gen_if.slave bus
);

    typedef enum logic [2:0] {
        S_STRETCH,
        S_IDLE,
        S_PRESS_WAIT,
        S_HELD,
        S_REL_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STR_LAST = CNT_W'(STRETCH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sync_q, sync_d;
    logic             core_rst_n_q, core_rst_n_d;
    logic             key_level_q, key_level_d;
    logic             press_pulse_q, press_pulse_d;
    logic             key_s;

    // Synchroniser resets to "released" so a reset never looks like a press.
    assign key_s = ~sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_STRETCH;
            cnt_q         <= '0;
            sync_q        <= 2'b11;
            core_rst_n_q  <= 1'b0;
            key_level_q   <= 1'b0;
            press_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sync_q        <= sync_d;
            core_rst_n_q  <= core_rst_n_d;
            key_level_q   <= key_level_d;
            press_pulse_q <= press_pulse_d;
        end
    end

    always_comb begin
        sync_d        = {sync_q[0], bus.key_n};
        state_d       = state_q;
        cnt_d         = cnt_q;
        core_rst_n_d  = core_rst_n_q;
        key_level_d   = key_level_q;
        press_pulse_d = 1'b0;

        case (state_q)
            S_STRETCH: begin
                if (cnt_q == STR_LAST) begin
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                    core_rst_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_IDLE: begin
                if (key_s) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end

            S_PRESS_WAIT: begin
                if (!key_s) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d       = S_HELD;
                    cnt_d         = '0;
                    key_level_d   = 1'b1;
                    press_pulse_d = 1'b1;
                    core_rst_n_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_HELD: begin
                core_rst_n_d = 1'b0;
                key_level_d  = 1'b1;
                if (!key_s) begin
                    state_d = S_REL_WAIT;
                    cnt_d   = '0;
                end
            end

            // Core stays in reset through release; S_STRETCH raises it later.
            S_REL_WAIT: begin
                if (key_s) begin
                    state_d = S_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = S_STRETCH;
                    cnt_d       = '0;
                    key_level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d      = S_STRETCH;
                cnt_d        = '0;
                core_rst_n_d = 1'b0;
                key_level_d  = 1'b0;
            end
        endcase
    end

    assign bus.core_rst_n  = core_rst_n_q;
    assign bus.key_level   = key_level_q;
    assign bus.press_pulse = press_pulse_q;

endmodule

// File: tb/tb_key_reset_gen.sv
// tb/tb_key_reset_gen.sv - scoreboard bench for key_reset_gen against a run-length reference model
module tb_key_reset_gen;

    localparam int DEB = 4;
    localparam int STR = 3;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    key_reset_gen_if bus_if ();

    key_reset_gen #(
        .DEBOUNCE_CYCLES(DEB),
        .STRETCH_CYCLES (STR),
        .CNT_W          (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    logic [2:0] exp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;

    // Reference: a press/release is accepted after DEB+1 consecutive
    // qualifying samples of the 2-cycle-delayed key; reset stretch is STR edges.
    int  m_stretch_left;
    int  m_run;
    bit  m_level, m_core, m_pulse;
    bit  m_h0, m_h1;
    bit  m_ks;

    task automatic model_reset();
        m_stretch_left = STR;
        m_run          = 0;
        m_level        = 1'b0;
        m_core         = 1'b0;
        m_pulse        = 1'b0;
        m_h0           = 1'b1;
        m_h1           = 1'b1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) begin
                model_reset();
            end else begin
                m_ks    = !m_h1;
                m_h1    = m_h0;
                m_h0    = bus_if.key_n;
                m_pulse = 1'b0;
                if (m_stretch_left > 0) begin
                    m_stretch_left = m_stretch_left - 1;
                    m_run          = 0;
                    if (m_stretch_left == 0) m_core = 1'b1;
                end else if (!m_level) begin
                    m_run = m_ks ? m_run + 1 : 0;
                    if (m_run == DEB + 1) begin
                        m_level = 1'b1;
                        m_pulse = 1'b1;
                        m_core  = 1'b0;
                        m_run   = 0;
                    end
                end else begin
                    m_run = !m_ks ? m_run + 1 : 0;
                    if (m_run == DEB + 1) begin
                        m_level        = 1'b0;
                        m_stretch_left = STR;
                        m_run          = 0;
                    end
                end
            end
            exp_q.push_back({m_core, m_level, m_pulse});
        end
    end

    logic [2:0] mon_exp, mon_act;

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_act = {bus_if.core_rst_n, bus_if.key_level, bus_if.press_pulse};
                vectors++;
                if (mon_act !== mon_exp) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t {core_rst_n,key_level,press_pulse} actual=%b required=%b",
                             $time, mon_act, mon_exp);
                end
            end
        end
    end

    task automatic hold(input bit kn, input int n);
        @(negedge clk);
        #2;
        bus_if.key_n = kn;
        if (n > 1) repeat (n - 1) @(negedge clk);
    endtask

    task automatic pulse_rst(input int n);
        @(negedge clk);
        #2;
        rst = 1'b1;
        repeat (n) @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus_if.key_n = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        hold(1'b1, 6);

        hold(1'b0, 12);
        hold(1'b1, 2);
        hold(1'b0, 1);
        hold(1'b1, 10);
        hold(1'b1, 6);

        hold(1'b0, 3);
        hold(1'b1, 8);

        hold(1'b0, 5);
        pulse_rst(2);
        hold(1'b1, 8);

        hold(1'b0, 1);
        pulse_rst(2);
        hold(1'b0, 15);
        hold(1'b1, 15);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) pulse_rst(int'($urandom_range(1, 3)));
            else hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 10)));
        end

        hold(1'b1, 20);
        @(negedge clk);
        #3;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending_expected actual=%0d required=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
